cond_branch_eval: RTL
=====================

// Module: cond_branch_eval
// PURPOSE
//  Parametrised, pipelined successor to the combinational 3-bit condition checker.
//  Evaluates cond (never,=0,<0,<=0,always,!=0,>=0,>0) on a WIDTH-bit value in signed or unsigned mode.
//  Resolves the branch: next_pc = taken ? target : pc+1. Keeps taken/eval statistics.
//  Sits between the register-file read stage and the PC/fetch unit; valid/ready on both sides.
// PARAMETERS
//  WIDTH   8   operand width in bits (>=2)
//  ADDR_W  8   PC / target width in bits
//  CNT_W   16  width of the saturating statistics counters
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  flush      in   1       sync: drop all in-flight ops
//  in_valid   in   1       input op valid
//  in_ready   out  1       block can accept op this cycle
//  in_value   in   WIDTH   operand to test
//  in_cond    in   3       condition code
//  in_signed  in   1       1 = two's-complement, 0 = unsigned
//  in_pc      in   ADDR_W  PC of the op
//  in_target  in   ADDR_W  branch target
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  out_taken  out  1       condition true
//  out_next_pc out ADDR_W  resolved next PC
//  cnt_clr    in   1       sync clear of both counters
//  eval_cnt   out  CNT_W   results delivered (saturating)
//  taken_cnt  out  CNT_W   taken results delivered (saturating)
// BEHAVIOUR
//  Reset (async, rst_n=0): s1/s2 valid=0, out_valid=0, out_taken=0, out_next_pc=0, counters=0.
//  Stage 1 registers the op plus flags Z=(value==0), N=in_signed & value[WIDTH-1], and pc+1.
//  Stage 2 registers taken and next_pc. Outputs come directly from stage-2 flops.
//  Latency: 2 cycles in->out with out_ready=1; throughput 1 op/cycle.
//  Cond map: 000 0 | 001 Z | 010 N | 011 N|Z | 100 1 | 101 !Z | 110 !N | 111 !N&!Z.
//  Unsigned mode forces N=0: <0 never, <=0 == Z, >=0 always, >0 == !Z.
//  pc+1 wraps mod 2^ADDR_W (pc=all-ones -> 0). No other arithmetic.
//  Handshake: s2 loads when !s2_valid | out_ready; s1 advances when s2 loads.
//    in_ready = !flush & (!s1_valid | s1_advance); ops accepted only on in_valid&in_ready.
//    out_* stable while out_valid & !out_ready. No combinational in_valid->in_ready path.
//  Flush: next cycle s1_valid=s2_valid=0. Input presented in the flush cycle is not taken
//    (in_ready=0). The output handshake in the flush cycle still counts.
//  Counters: +1 on out_valid&out_ready (taken_cnt only if out_taken); saturate at all-ones.
//    cnt_clr has priority over a same-cycle increment (result 0).
//  rst_n asserted mid-operation: all in-flight ops lost, outputs to reset values immediately.
// STRUCTURE
//  cond_pkg: localparams COND_NEVER..COND_GT (3'b000..3'b111); function cond_eval(z,n,cond).
//  Sub-module cond_flag_eval (combinational: z,n,cond -> taken), instantiated in stage 2.
//  Pipeline control and counters live in the top module.
// TESTING
//  W=8, in_signed=1: value 8'h80, cond 010, pc 5, tgt 20 -> 2 cyc later taken=1, next_pc=20.
//  in_signed=0: value 8'h80 -> cond 010 taken=0, next_pc=6; cond 110 taken=1; cond 111 taken=1.
//  Sweep all 8 conds for values 0, 1, 8'h7F, 8'h80, 8'hFF in both modes vs. model; pc=8'hFF -> next_pc 0.
//  Hold out_ready=0 3 cycles with 4 ops streamed -> in_ready drops after 2 accepted, outputs stable, order kept.
//  Flush with 2 ops in flight + in_valid=1 -> out_valid=0 next cycle, none of the 3 ops ever appears.
//  CNT_W=2: 5 taken results -> counters stick at 3; cnt_clr with a handshake in the same cycle -> 0.

Source files
------------

// File: rtl/cond_pkg.sv
// cond_pkg
//   Shared definitions for the conditional-branch evaluator.
//   - cond_t      : 3-bit condition code type
//   - COND_*      : condition code encodings (never, =0, <0, <=0, always, !=0, >=0, >0)
//   - cond_eval() : resolves a condition code from the zero (z) and negative (n) flags
package cond_pkg;

    typedef logic [2:0] cond_t;

    localparam cond_t COND_NEVER  = 3'b000;
    localparam cond_t COND_EQ     = 3'b001;
    localparam cond_t COND_LT     = 3'b010;
    localparam cond_t COND_LE     = 3'b011;
    localparam cond_t COND_ALWAYS = 3'b100;
    localparam cond_t COND_NE     = 3'b101;
    localparam cond_t COND_GE     = 3'b110;
    localparam cond_t COND_GT     = 3'b111;

    function automatic logic cond_eval(input logic z, input logic n, input cond_t cond);
        logic t;
        case (cond)
            COND_NEVER:  t = 1'b0;
            COND_EQ:     t = z;
            COND_LT:     t = n;
            COND_LE:     t = n | z;
            COND_ALWAYS: t = 1'b1;
            COND_NE:     t = ~z;
            COND_GE:     t = ~n;
            COND_GT:     t = ~n & ~z;
            default:     t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/cond_flag_eval.sv
// cond_flag_eval
//   Combinational condition resolver.
//   Ports:
//     z     in  1  operand was zero
//     n     in  1  operand was negative (always 0 in unsigned mode)
//     cond  in  3  condition code
//     taken out 1  condition holds
module cond_flag_eval
    import cond_pkg::*;
(
    input  logic  z,
    input  logic  n,
    input  cond_t cond,
    output logic  taken
);

    assign taken = cond_eval(z, n, cond);

endmodule

// File: rtl/cond_branch_eval.sv
// cond_branch_eval
//   Two-stage pipelined branch-condition evaluator with valid/ready on both sides.
//   Stage 1 captures the op with its zero/negative flags and pc+1; stage 2 resolves
//   the condition and the next PC. Saturating counters track delivered and taken results.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     flush                      drop all in-flight ops (sync)
//     in_valid / in_ready        input handshake
//     in_value, in_cond,
//     in_signed, in_pc, in_target  op fields
//     out_valid / out_ready      output handshake
//     out_taken, out_next_pc     resolved branch
//     cnt_clr                    sync clear of both counters (wins over increment)
//     eval_cnt, taken_cnt        saturating statistics
module cond_branch_eval
    import cond_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_value,
    input  cond_t             in_cond,
    input  logic              in_signed,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [ADDR_W-1:0] in_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_taken,
    output logic [ADDR_W-1:0] out_next_pc,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  eval_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic signed [WIDTH-1:0] value_s;
    logic                    z_flag;
    logic                    n_flag;

    logic                    vld_p1;
    cond_t                   cond_p1;
    logic                    z_p1;
    logic                    n_p1;
    logic [ADDR_W-1:0]       pc_inc_p1;
    logic [ADDR_W-1:0]       target_p1;

    logic                    vld_p2;
    logic                    taken_p2;
    logic [ADDR_W-1:0]       next_pc_p2;

    logic                    s2_load;
    logic                    s1_advance;
    logic                    accept;
    logic                    out_hs;
    logic                    taken_d;
    logic [ADDR_W-1:0]       next_pc_d;

    // Unsigned mode forces N low, so <0 never fires and >=0 always fires.
    assign value_s = $signed(in_value);
    assign z_flag  = (in_value == '0);
    assign n_flag  = in_signed & value_s[WIDTH-1];

    // in_ready depends only on registered state, flush and out_ready, never on in_valid.
    assign s2_load    = ~vld_p2 | out_ready;
    assign s1_advance = vld_p1 & s2_load;
    assign in_ready   = ~flush & (~vld_p1 | s1_advance);
    assign accept     = in_valid & in_ready;
    assign out_hs     = vld_p2 & out_ready;

    // ---- stage 1: capture op, flags and pc+1 ----
    always_ff @(posedge clk) begin
        if (accept) begin
            cond_p1   <= in_cond;
            z_p1      <= z_flag;
            n_p1      <= n_flag;
            pc_inc_p1 <= in_pc + ADDR_W'(1);
            target_p1 <= in_target;
        end
    end

    // ---- stage 2: resolve condition and next PC ----
    cond_flag_eval u_flag_eval (
        .z     (z_p1),
        .n     (n_p1),
        .cond  (cond_p1),
        .taken (taken_d)
    );

    assign next_pc_d = taken_d ? target_p1 : pc_inc_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            taken_p2   <= 1'b0;
            next_pc_p2 <= '0;
        end else begin
            if (flush)
                vld_p1 <= 1'b0;
            else if (accept)
                vld_p1 <= 1'b1;
            else if (s1_advance)
                vld_p1 <= 1'b0;

            if (flush)
                vld_p2 <= 1'b0;
            else if (s2_load)
                vld_p2 <= vld_p1;

            // Result flops only move on a real transfer so a stalled output holds still.
            if (s1_advance) begin
                taken_p2   <= taken_d;
                next_pc_p2 <= next_pc_d;
            end
        end
    end

    assign out_valid   = vld_p2;
    assign out_taken   = taken_p2;
    assign out_next_pc = next_pc_p2;

    // ---- statistics: count delivered results, clear wins over increment ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_cnt  <= '0;
            taken_cnt <= '0;
        end else if (cnt_clr) begin
            eval_cnt  <= '0;
            taken_cnt <= '0;
        end else if (out_hs) begin
            eval_cnt <= sat_inc(eval_cnt);
            if (taken_p2)
                taken_cnt <= sat_inc(taken_cnt);
        end
    end

endmodule
